fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/rv32i_types_pkg.sv | 22 ++
 rtl/fetch_buffer_if.sv | 46 ++++
 rtl/fetch_buffer_ram.sv | 42 ++++
 rtl/fetch_buffer.sv | 138 +++++++++++++
 tb/tb_fetch_buffer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_types_pkg
// Description : Shared RV32I types for the fetch path (word type, fetch slot
//               entry, canonical NOP encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    // addi x0, x0, 0
    localparam word_t FETCH_NOP = 32'h0000_0013;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  fault;
    } fetch_entry_t;

endpackage : rv32i_types_pkg
`default_nettype wire

// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface   : fetch_buffer_if
// Description : PC-generator, instruction-memory and decode handshakes of the
//               fetch buffer. master = environment, slave = fetch_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_buffer_if;
    import rv32i_types_pkg::*;

    logic  fetch_req_valid;
    word_t fetch_req_pc;
    logic  fetch_req_ready;

    logic  imem_ren;
    word_t imem_addr;
    logic  imem_gnt;
    logic  imem_rvalid;
    word_t imem_rdata;
    logic  imem_fault;

    logic  instr_valid;
    word_t instr;
    word_t instr_pc;
    logic  instr_fault;
    logic  decode_ready;
    logic  flush;

    modport master (
        output fetch_req_valid, fetch_req_pc,
        output imem_gnt, imem_rvalid, imem_rdata, imem_fault,
        output decode_ready, flush,
        input  fetch_req_ready, imem_ren, imem_addr,
        input  instr_valid, instr, instr_pc, instr_fault
    );

    modport slave (
        input  fetch_req_valid, fetch_req_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, imem_fault,
        input  decode_ready, flush,
        output fetch_req_ready, imem_ren, imem_addr,
        output instr_valid, instr, instr_pc, instr_fault
    );

endinterface : fetch_buffer_if
`default_nettype wire

// File: rtl/fetch_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_ram
// Description : DEPTH x fetch_entry_t slot storage with a PC write port, an
//               instruction/fault fill port and an asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer_ram
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          pc_we_i,
    input  logic [AW-1:0] pc_addr_i,
    input  word_t         pc_i,
    input  logic          fill_we_i,
    input  logic [AW-1:0] fill_addr_i,
    input  word_t         fill_instr_i,
    input  logic          fill_fault_i,
    input  logic [AW-1:0] rd_addr_i,
    output fetch_entry_t  rd_data_o
);

    fetch_entry_t mem_q [DEPTH];

    // PC and response land in different cycles, so the two ports own disjoint fields
    always_ff @(posedge CLK) begin
        if (pc_we_i) begin
            mem_q[pc_addr_i].pc <= pc_i;
        end
        if (fill_we_i) begin
            mem_q[fill_addr_i].instr <= fill_instr_i;
            mem_q[fill_addr_i].fault <= fill_fault_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : fetch_buffer_ram
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : In-order instruction fetch buffer with alloc/fill/read
//               pointers and flush-time drop counting of in-flight responses.
//               Optional macro FETCH_BUFFER_BYPASS_EN enables zero-latency
//               presentation of a response when no filled slot is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    ptr_t alloc_q, alloc_d;
    ptr_t fill_q,  fill_d;
    ptr_t read_q,  read_d;
    ptr_t drop_q,  drop_d;

    ptr_t         w_occupied;
    ptr_t         w_in_flight;
    logic         w_has_free;
    logic         w_req;
    logic         w_accept;
    logic         w_take;
    logic         w_buf_valid;
    logic         w_bypass;
    logic         w_valid;
    logic         w_pop;
    logic         w_fill_we;
    fetch_entry_t w_head;
    word_t        w_instr;
    word_t        w_instr_pc;
    logic         w_instr_fault;

    assign w_occupied  = alloc_q - read_q;
    assign w_in_flight = alloc_q - fill_q;

    // Responses still owed to dropped slots count against capacity too
    assign w_has_free  = (w_occupied + drop_q) < DEPTH_P;
    assign w_req       = nRST && bus.fetch_req_valid && w_has_free && !bus.flush;
    assign w_accept    = w_req && bus.imem_gnt;
    assign w_take      = nRST && bus.imem_rvalid && (drop_q == '0) && !bus.flush;
    assign w_buf_valid = (read_q != fill_q);

`ifdef FETCH_BUFFER_BYPASS_EN
    assign w_bypass = w_take && !w_buf_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid   = w_buf_valid || w_bypass;
    assign w_pop     = w_valid && bus.decode_ready && !bus.flush;
    assign w_fill_we = w_take && !(w_bypass && bus.decode_ready);

    always_comb begin
        alloc_d = alloc_q + ptr_t'(w_accept);
        fill_d  = fill_q  + ptr_t'(w_take);
        read_d  = read_q  + ptr_t'(w_pop);
        drop_d  = drop_q;
        if (bus.flush) begin
            alloc_d = alloc_q + ptr_t'(w_accept);
            fill_d  = alloc_d;
            read_d  = alloc_d;
            // Any response seen this cycle is one of the in-flight ones, already discarded
            drop_d  = drop_q + w_in_flight + ptr_t'(w_accept) - ptr_t'(bus.imem_rvalid);
        end else if (bus.imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - ptr_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            alloc_q <= '0;
            fill_q  <= '0;
            read_q  <= '0;
            drop_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            read_q  <= read_d;
            drop_q  <= drop_d;
        end
    end

    fetch_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .CLK          (CLK),
        .pc_we_i      (w_accept),
        .pc_addr_i    (alloc_q[AW-1:0]),
        .pc_i         (bus.fetch_req_pc),
        .fill_we_i    (w_fill_we),
        .fill_addr_i  (fill_q[AW-1:0]),
        .fill_instr_i (bus.imem_rdata),
        .fill_fault_i (bus.imem_fault),
        .rd_addr_i    (read_q[AW-1:0]),
        .rd_data_o    (w_head)
    );

    always_comb begin
        w_instr       = FETCH_NOP;
        w_instr_pc    = '0;
        w_instr_fault = 1'b0;
        if (w_bypass) begin
            w_instr       = bus.imem_rdata;
            w_instr_pc    = w_head.pc;
            w_instr_fault = bus.imem_fault;
        end else if (w_buf_valid) begin
            w_instr       = w_head.instr;
            w_instr_pc    = w_head.pc;
            w_instr_fault = w_head.fault;
        end
    end

    assign bus.imem_ren        = w_req;
    assign bus.imem_addr       = bus.fetch_req_pc;
    assign bus.fetch_req_ready = w_accept;
    assign bus.instr_valid     = w_valid;
    assign bus.instr           = w_instr;
    assign bus.instr_pc        = w_instr_pc;
    assign bus.instr_fault     = w_instr_fault;

endmodule : fetch_buffer
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Directed self-checking bench for fetch_buffer (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_buffer_if bus ();

    fetch_buffer #(
        .DEPTH (2)
    ) u_dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_req_valid = 1'b0;
        bus.fetch_req_pc    = 32'h0;
        bus.imem_gnt        = 1'b0;
        bus.imem_rvalid     = 1'b0;
        bus.imem_rdata      = 32'h0;
        bus.imem_fault      = 1'b0;
        bus.flush           = 1'b0;
    endtask

    task automatic req(input logic [31:0] pc);
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_pc    = pc;
        bus.imem_gnt        = 1'b1;
    endtask

    task automatic resp(input logic [31:0] data, input logic fault);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        bus.imem_fault  = fault;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with busy inputs
        idle();
        bus.decode_ready = 1'b0;
        req(32'h0000_0100);
        resp(32'hDEAD_BEEF, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_ren",   32'(bus.imem_ren),        32'h0);
        chk("rst_ready", 32'(bus.fetch_req_ready), 32'h0);
        chk("rst_valid", 32'(bus.instr_valid),     32'h0);
        chk("rst_instr", bus.instr,                32'h0000_0013);
        chk("rst_pc",    bus.instr_pc,             32'h0);
        chk("rst_fault", 32'(bus.instr_fault),     32'h0);
        idle();
        nrst = 1'b1;

        // two in-order fetches, decode always ready
        tick(); idle(); bus.decode_ready = 1'b1; req(32'h200); #1;
        chk("a_ren",   32'(bus.imem_ren),        32'h1);
        chk("a_addr",  bus.imem_addr,            32'h200);
        chk("a_ready", 32'(bus.fetch_req_ready), 32'h1);
        tick(); idle(); req(32'h204); resp(32'hAAAA_0001, 1'b0); #1;
        chk("a_ready2",  32'(bus.fetch_req_ready), 32'h1);
        chk("a_latency", 32'(bus.instr_valid),     32'h0);
        tick(); idle(); resp(32'hAAAA_0002, 1'b0); #1;
        chk("a_v0",  32'(bus.instr_valid), 32'h1);
        chk("a_pc0", bus.instr_pc,         32'h200);
        chk("a_i0",  bus.instr,            32'hAAAA_0001);
        tick(); idle(); #1;
        chk("a_v1",  32'(bus.instr_valid), 32'h1);
        chk("a_pc1", bus.instr_pc,         32'h204);
        chk("a_i1",  bus.instr,            32'hAAAA_0002);
        tick(); idle(); #1;
        chk("a_empty", 32'(bus.instr_valid), 32'h0);

        // back-pressure: full after two grants, no same-cycle slot reuse
        tick(); idle(); bus.decode_ready = 1'b0; req(32'h200); #1;
        chk("b_rdy0", 32'(bus.fetch_req_ready), 32'h1);
        tick(); idle(); req(32'h204); resp(32'hBBBB_0001, 1'b0); #1;
        chk("b_rdy1", 32'(bus.fetch_req_ready), 32'h1);
        tick(); idle(); req(32'h208); resp(32'hBBBB_0002, 1'b0); #1;
        chk("b_full_ren", 32'(bus.imem_ren),        32'h0);
        chk("b_full_rdy", 32'(bus.fetch_req_ready), 32'h0);
        chk("b_hold_pc",  bus.instr_pc,             32'h200);
        tick(); idle(); req(32'h208); bus.decode_ready = 1'b1; #1;
        chk("b_noreuse", 32'(bus.imem_ren), 32'h0);
        chk("b_hold_i",  bus.instr,         32'hBBBB_0001);
        tick(); idle(); req(32'h208); bus.decode_ready = 1'b0; #1;
        chk("b_issue_ren",  32'(bus.imem_ren), 32'h1);
        chk("b_issue_addr", bus.imem_addr,     32'h208);
        chk("b_pc",         bus.instr_pc,      32'h204);
        tick(); idle(); bus.decode_ready = 1'b1; resp(32'hBBBB_0003, 1'b0); #1;
        chk("b_i1", bus.instr, 32'hBBBB_0002);
        tick(); idle(); #1;
        chk("b_pc2", bus.instr_pc, 32'h208);
        chk("b_i2",  bus.instr,    32'hBBBB_0003);
        tick(); idle(); #1;
        chk("b_empty", 32'(bus.instr_valid), 32'h0);

        // flush with two requests in flight
        tick(); idle(); req(32'h280);
        tick(); idle(); req(32'h284);
        tick(); idle(); req(32'h400); bus.flush = 1'b1; #1;
        chk("c_flush_ren", 32'(bus.imem_ren), 32'h0);
        tick(); idle(); req(32'h400); resp(32'h5555_0001, 1'b0); #1;
        chk("c_v_after",  32'(bus.instr_valid), 32'h0);
        chk("c_drain_ren", 32'(bus.imem_ren),   32'h0);
        tick(); idle(); req(32'h400); resp(32'h5555_0002, 1'b0); #1;
        chk("c_ren",  32'(bus.imem_ren),    32'h1);
        chk("c_addr", bus.imem_addr,        32'h400);
        chk("c_v",    32'(bus.instr_valid), 32'h0);
        tick(); idle(); resp(32'hCCCC_0400, 1'b0); #1;
        chk("c_v2", 32'(bus.instr_valid), 32'h0);
        tick(); idle(); #1;
        chk("c_v3", 32'(bus.instr_valid), 32'h1);
        chk("c_pc", bus.instr_pc,         32'h400);
        chk("c_i",  bus.instr,            32'hCCCC_0400);
        tick(); idle(); #1;
        chk("c_empty", 32'(bus.instr_valid), 32'h0);

        // flush coincident with a response and an offered grant
        tick(); idle(); req(32'h480);
        tick(); idle(); req(32'h484);
        tick(); idle(); req(32'h500); bus.flush = 1'b1; resp(32'h5555_0003, 1'b0); #1;
        chk("d_ren", 32'(bus.imem_ren),        32'h0);
        chk("d_rdy", 32'(bus.fetch_req_ready), 32'h0);
        chk("d_v0",  32'(bus.instr_valid),     32'h0);
        tick(); idle(); req(32'h500); resp(32'h5555_0004, 1'b0); #1;
        chk("d_v",     32'(bus.instr_valid), 32'h0);
        chk("d_ren2",  32'(bus.imem_ren),    32'h1);
        tick(); idle(); resp(32'hDDDD_0500, 1'b0); #1;
        chk("d_v2", 32'(bus.instr_valid), 32'h0);
        tick(); idle(); #1;
        chk("d_v3", 32'(bus.instr_valid), 32'h1);
        chk("d_pc", bus.instr_pc,         32'h500);
        chk("d_i",  bus.instr,            32'hDDDD_0500);
        tick(); idle(); #1;
        chk("d_empty", 32'(bus.instr_valid), 32'h0);

        // access fault
        tick(); idle(); req(32'h300);
        tick(); idle(); resp(32'h0BAD_0BAD, 1'b1); #1;
        chk("e_v_pre", 32'(bus.instr_valid), 32'h0);
        tick(); idle(); #1;
        chk("e_v",     32'(bus.instr_valid), 32'h1);
        chk("e_fault", 32'(bus.instr_fault), 32'h1);
        chk("e_pc",    bus.instr_pc,         32'h300);
        tick(); idle(); #1;
        chk("e_fault_clr", 32'(bus.instr_fault), 32'h0);
        chk("e_empty",     32'(bus.instr_valid), 32'h0);

        // asynchronous reset mid-stream
        tick(); idle(); bus.decode_ready = 1'b0; req(32'h600);
        tick(); idle(); req(32'h604); resp(32'hFFFF_0600, 1'b0);
        tick(); idle(); #1;
        chk("f_v",  32'(bus.instr_valid), 32'h1);
        chk("f_pc", bus.instr_pc,         32'h600);
        nrst = 1'b0;
        resp(32'hFFFF_0604, 1'b0);
        #1;
        chk("f_rst_v",  32'(bus.instr_valid), 32'h0);
        chk("f_rst_i",  bus.instr,            32'h0000_0013);
        chk("f_rst_pc", bus.instr_pc,         32'h0);
        tick(); idle(); resp(32'hFFFF_0BAD, 1'b0); #1;
        chk("f_hold_v", 32'(bus.instr_valid), 32'h0);
        idle();
        nrst = 1'b1;
        tick(); idle(); #1;
        chk("f_after_v", 32'(bus.instr_valid), 32'h0);
        tick(); idle(); bus.decode_ready = 1'b1; req(32'h700); #1;
        chk("f_ren7", 32'(bus.imem_ren), 32'h1);
        tick(); idle(); resp(32'hFFFF_0700, 1'b0);
        tick(); idle(); #1;
        chk("f_v7",  32'(bus.instr_valid), 32'h1);
        chk("f_pc7", bus.instr_pc,         32'h700);
        chk("f_i7",  bus.instr,            32'hFFFF_0700);
        tick(); idle(); #1;
        chk("f_empty", 32'(bus.instr_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_buffer
`default_nettype wire
